// File: rtl/aud_timers.sv
// aud_timers: POKEY four-channel audio frequency dividers.
// Generates per-channel Timer underflow pulses, the high-pass clock and
// disable lines, and the audio-phase reset pulse on STIMER.
// Build macro: AUD_TIMERS_JOIN_EN builds the 16-bit channel join logic
// (AUDCTL[4] joins ch2:ch1, AUDCTL[3] joins ch4:ch3) with 17-bit counters.
// Without it, AUDCTL[4:3] are ignored and every channel runs unjoined.
module aud_timers (
    input  logic       clk,
    input  logic       rst,
    input  logic       enn,
    input  logic [7:0] D,
    input  logic [3:0] AUDF,
    input  logic       AUDCTL,
    input  logic       STIMER,
    output logic [3:0] Timer,
    output logic [3:0] Timerx,
    output logic [3:0] disHiFltr,
    output logic       rstAudPhase,
    output logic       poly9Sel
);

`ifdef AUD_TIMERS_JOIN_EN
    localparam int LW = 17;
`else
    localparam int LW = 9;
`endif

    logic [7:0] audf_reg [4];
    logic [7:0] audctl_reg;
    logic [4:0] pre28_reg;
    logic [6:0] pre114_reg;
    logic [3:0] timer_reg;
    logic       rst_phase_reg;
    logic [3:0] pulse_next;
    logic       audctl_wr;
    logic       stimer_wr;
    logic       tick64;
    logic       tick15;
    logic       base;
    logic [7:0] ctl_new;
    logic       unused_ctl;

    assign audctl_wr = enn & AUDCTL;
    assign stimer_wr = enn & STIMER;
    // Control value as it will be after this cycle; reloads forced this
    // cycle (STIMER, mode change) must already see a simultaneous write.
    assign ctl_new   = audctl_wr ? D : audctl_reg;
    assign tick64    = enn & (pre28_reg == 5'd27);
    assign tick15    = enn & (pre114_reg == 7'd113);
    assign base      = audctl_reg[0] ? tick15 : tick64;

`ifdef AUD_TIMERS_JOIN_EN
    // Low-counter reload: 16-bit pair value when joined, else 8-bit AUDF.
    function automatic logic [LW-1:0] lo_reload(input logic fast, input logic joined,
                                                 input logic [7:0] lo, input logic [7:0] hi);
        logic [LW-1:0] v;
        if (joined)
            v = {1'b0, hi, lo} + (fast ? 17'd6 : 17'd0);
        else
            v = {9'd0, lo} + (fast ? 17'd3 : 17'd0);
        return v;
    endfunction
    assign unused_ctl = ^{ctl_new[7], ctl_new[2:1]};
`else
    // Low-counter reload for an unjoined channel.
    function automatic logic [LW-1:0] lo_reload(input logic fast, input logic [7:0] lo);
        return {1'b0, lo} + (fast ? 9'd3 : 9'd0);
    endfunction
    assign unused_ctl = ^{ctl_new[7], ctl_new[4:1], audctl_reg[4:3]};
`endif

    // Register file: AUDF1-4 and AUDCTL latch D on enn-qualified strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) audf_reg[i] <= '0;
            audctl_reg <= '0;
        end else if (enn) begin
            for (int i = 0; i < 4; i++) begin
                if (AUDF[i]) audf_reg[i] <= D;
            end
            if (AUDCTL) audctl_reg <= D;
        end
    end

    // Free-running prescaler: 64 kHz tick every 28 enn, 15 kHz every 114.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre28_reg  <= '0;
            pre114_reg <= '0;
        end else if (enn) begin
            pre28_reg  <= (pre28_reg == 5'd27) ? 5'd0 : pre28_reg + 5'd1;
            pre114_reg <= (pre114_reg == 7'd113) ? 7'd0 : pre114_reg + 7'd1;
        end
    end

    // Channel pairs: gi=0 is ch1/ch2, gi=1 is ch3/ch4.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pair
            localparam int LO       = 2 * gi;
            localparam int HI       = 2 * gi + 1;
            localparam int FAST_BIT = 6 - gi;

            logic [LW-1:0] cnt_lo_reg;
            logic [8:0]    cnt_hi_reg;
            logic          fast_cur;
            logic          fast_new;
            logic          join_cur;
            logic          join_new;
            logic          mode_chg;
            logic          reload_all;
            logic          src_lo;
            logic [LW-1:0] reload_lo_cur;
            logic [LW-1:0] reload_lo_new;
            logic [8:0]    reload_hi;
            logic [1:0]    pulse;

            assign fast_cur = audctl_reg[FAST_BIT];
            assign fast_new = ctl_new[FAST_BIT];
`ifdef AUD_TIMERS_JOIN_EN
            localparam int JOIN_BIT = 4 - gi;
            assign join_cur      = audctl_reg[JOIN_BIT];
            assign join_new      = ctl_new[JOIN_BIT];
            assign reload_lo_cur = lo_reload(fast_cur, join_cur, audf_reg[LO], audf_reg[HI]);
            assign reload_lo_new = lo_reload(fast_new, join_new, audf_reg[LO], audf_reg[HI]);
`else
            assign join_cur      = 1'b0;
            assign join_new      = 1'b0;
            assign reload_lo_cur = lo_reload(fast_cur, audf_reg[LO]);
            assign reload_lo_new = lo_reload(fast_new, audf_reg[LO]);
`endif
            assign reload_hi  = {1'b0, audf_reg[HI]};
            // Any change of clock source or join for this pair restarts it.
            assign mode_chg   = audctl_wr & ((fast_new != fast_cur) |
                                             (join_new != join_cur) |
                                             (ctl_new[0] != audctl_reg[0]));
            assign reload_all = stimer_wr | mode_chg;
            assign src_lo     = fast_cur ? enn : base;

            // Underflow detection; a forced reload suppresses the pulse.
            always_comb begin
                pulse = 2'b00;
                if (!reload_all) begin
                    if (src_lo && cnt_lo_reg == '0) begin
                        if (join_cur) pulse[1] = 1'b1;
                        else          pulse[0] = 1'b1;
                    end
                    if (!join_cur && base && cnt_hi_reg == '0) pulse[1] = 1'b1;
                end
            end
            assign pulse_next[HI:LO] = pulse;

            // Down-counters: reload at zero, forced reload on STIMER/mode change.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_lo_reg <= '0;
                    cnt_hi_reg <= '0;
                end else if (enn) begin
                    if (reload_all) begin
                        cnt_lo_reg <= reload_lo_new;
                        cnt_hi_reg <= reload_hi;
                    end else begin
                        if (src_lo)
                            cnt_lo_reg <= (cnt_lo_reg == '0) ? reload_lo_cur
                                                             : cnt_lo_reg - LW'(1);
                        if (!join_cur && base)
                            cnt_hi_reg <= (cnt_hi_reg == '0) ? reload_hi
                                                             : cnt_hi_reg - 9'd1;
                    end
                end
            end
        end
    endgenerate

    // Output pulses held for exactly one enn period.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_reg     <= '0;
            rst_phase_reg <= 1'b0;
        end else if (enn) begin
            timer_reg     <= pulse_next;
            rst_phase_reg <= STIMER;
        end
    end

    assign Timer       = timer_reg;
    assign Timerx      = {2'b00, timer_reg[3], timer_reg[2]};
    assign disHiFltr   = {2'b11, ~audctl_reg[1], ~audctl_reg[2]};
    assign rstAudPhase = rst_phase_reg;
    assign poly9Sel    = audctl_reg[7];

endmodule
